ysyx_23060171_ifu: RTL

//  Instruction fetch unit for the multi-cycle core.
//  - Holds the PC and issues one request per instruction to instruction memory over a valid/ready bus.
//  - Captures the returned word and hands {inst, pc} to the decode stage; decode drives the imm generator from inst.
//  - After handoff, waits for the next PC (dnpc) from writeback before fetching again. At most one fetch is outstanding.

---
 rtl/ysyx_23060171_pkg.sv | 30 +++
 rtl/ysyx_23060171_Reg.sv | 31 +++
 rtl/ysyx_23060171_ifu.sv | 114 +++++++++++
 3 files changed

// File: rtl/ysyx_23060171_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060171_pkg
// Description : Shared IFU definitions: FSM state encoding, fault codes,
//               NOP encoding and reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060171_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ACCESS   = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_NPC  = 3'd4
  } ifu_state_t;

  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060171_Reg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060171_Reg
// Description : WIDTH-bit register with write enable and async reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060171_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_wen) begin
      r_q <= i_din;
    end
  end

  assign o_dout = r_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060171_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060171_ifu
// Description : Multi-cycle instruction fetch unit; one outstanding imem
//               request, hands {inst, pc, fault} to decode, waits for dnpc.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060171_ifu
  import ysyx_23060171_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      out_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc
);

  ifu_state_t      r_state;
  logic [XLEN-1:0] r_outInst;
  logic [XLEN-1:0] r_outPc;
  logic [1:0]      r_outFault;
  logic [XLEN-1:0] w_pc;
  logic            w_pcWen;
  logic            w_pcAligned;

  // pc only changes on a dnpc delivery; the IFU never increments it.
  assign w_pcWen     = (r_state == S_NPC) && npc_valid;
  assign w_pcAligned = isWordAligned(w_pc[1:0]);

  ysyx_23060171_Reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pcReg (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_pcWen),
    .i_din  (npc),
    .o_dout (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_outInst  <= '0;
      r_outPc    <= RESET_PC;
      r_outFault <= FAULT_NONE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // A misaligned pc never reaches memory; it is reported as a fault.
          if (!w_pcAligned) begin
            r_outInst  <= NOP_INST;
            r_outPc    <= w_pc;
            r_outFault <= FAULT_MISALIGN;
            r_state    <= S_OUT;
          end else if (imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_outInst  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
            r_outPc    <= w_pc;
            r_outFault <= imem_rsp_err ? FAULT_ACCESS : FAULT_NONE;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state <= S_NPC;
          end
        end
        S_NPC: begin
          if (npc_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ) && w_pcAligned;
  assign imem_req_addr  = w_pc;
  assign out_valid      = (r_state == S_OUT);
  assign out_inst       = r_outInst;
  assign out_pc         = r_outPc;
  assign out_fault      = r_outFault;

`ifndef SYNTHESIS
  a_rspOnlyInWait: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (r_state == S_WAIT));
  a_npcOnlyInNpc: assert property (@(posedge clk) disable iff (rst)
    npc_valid |-> (r_state == S_NPC));
  a_reqHeld: assert property (@(posedge clk) disable iff (rst)
    (imem_req_valid && !imem_req_ready) |=> imem_req_valid);
`endif

endmodule
`default_nettype wire
